// File: rtl/mini_alu_pkg.sv
// Shared opcode encodings, instruction field positions and core state type
// for the MiniAlu execution core.
package mini_alu_pkg;

    localparam int unsigned INSTR_WIDTH = 28;
    localparam int unsigned FIELD_WIDTH = 8;
    localparam int unsigned OP_LSB      = 24;
    localparam int unsigned DST_LSB     = 16;
    localparam int unsigned SRC1_LSB    = 8;
    localparam int unsigned SRC0_LSB    = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_STO  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_INC  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_BGE  = 4'd7,
        OP_BLE  = 4'd8,
        OP_BEQ  = 4'd9,
        OP_JMP  = 4'd10,
        OP_CALL = 4'd11,
        OP_RET  = 4'd12,
        OP_VGA  = 4'd13,
        OP_HALT = 4'd14
    } op_e;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } core_state_e;

    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = {OP_NOP, 24'h000000};

    function automatic logic [INSTR_WIDTH-1:0] mk_instr(op_e op, logic [7:0] dst,
                                                        logic [7:0] src1, logic [7:0] src0);
        return {op, dst, src1, src0};
    endfunction

endpackage

// File: rtl/mini_alu_core_if.sv
// Instruction ROM, pixel-write and status signals of the MiniAlu core.
interface mini_alu_core_if #(
    parameter int unsigned IADDR_WIDTH = 16,
    parameter int unsigned PIXEL_WIDTH = 3
);
    logic [IADDR_WIDTH-1:0] oRomAddr;
    logic [27:0]            iRomData;
    logic                   oPixWe;
    logic [7:0]             oPixX;
    logic [7:0]             oPixY;
    logic [PIXEL_WIDTH-1:0] oPixColor;
    logic                   oHalted;
    logic                   oStackErr;
    logic                   oIllegal;

    modport master (
        output oRomAddr, input iRomData,
        output oPixWe, output oPixX, output oPixY, output oPixColor,
        output oHalted, output oStackErr, output oIllegal
    );

    modport slave (
        input oRomAddr, output iRomData,
        input oPixWe, input oPixX, input oPixY, input oPixColor,
        input oHalted, input oStackErr, input oIllegal
    );
endinterface

// File: rtl/mini_alu_core_return_stack.sv
// Hardware return-address LIFO; push is ignored when full, pop when empty.
module return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned SPW = $clog2(DEPTH + 1);

    logic [SPW-1:0]   sp_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full_o  = (sp_q == SPW'(DEPTH));
    assign empty_o = (sp_q == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst_ni && push_i && !full_o && sp_q == SPW'(i)) begin
                mem_q[i] <= data_i;
            end
        end
    end

    always_comb begin
        top_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                top_o = mem_q[i];
            end
        end
    end
endmodule

// File: rtl/mini_alu_core.sv
// MiniAlu single-stage execution core: zero-penalty branches, nested CALL/RET,
// registered pixel-write port, sticky stack error and illegal-opcode pulse.
module mini_alu_core
    import mini_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned IADDR_WIDTH    = 16,
    parameter int unsigned REG_ADDR_WIDTH = 3,
    parameter int unsigned STACK_DEPTH    = 4,
    parameter int unsigned PIXEL_WIDTH    = 3
) (
    input  logic           Clock,
    input  logic           Reset,
    mini_alu_core_if.master bus
);
    localparam int unsigned NREGS = 2 ** REG_ADDR_WIDTH;

    core_state_e            state_q, state_d;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [IADDR_WIDTH-1:0] pc_q, fetch_addr, target;
    logic [DATA_WIDTH-1:0]  rf_q [NREGS];
    logic                   err_q, illegal_q, illegal_d, pix_we_q, pix_we_d;
    logic [7:0]             pix_x_q, pix_y_q;
    logic [PIXEL_WIDTH-1:0] pix_col_q;

    logic [3:0]             op;
    logic [7:0]             dst, src1, src0;
    logic [DATA_WIDTH-1:0]  rs1, rs0, imm, wdata;
    logic                   wr_en, taken, push, pop, set_err;
    logic [IADDR_WIDTH-1:0] st_top;
    logic                   st_full, st_empty;

    assign op   = ir_q[OP_LSB +: 4];
    assign dst  = ir_q[DST_LSB +: FIELD_WIDTH];
    assign src1 = ir_q[SRC1_LSB +: FIELD_WIDTH];
    assign src0 = ir_q[SRC0_LSB +: FIELD_WIDTH];
    assign rs1  = rf_q[src1[REG_ADDR_WIDTH-1:0]];
    assign rs0  = rf_q[src0[REG_ADDR_WIDTH-1:0]];
    assign imm  = DATA_WIDTH'({src1, src0});

    return_stack #(
        .DEPTH(STACK_DEPTH),
        .WIDTH(IADDR_WIDTH)
    ) u_stack (
        .clk_i  (Clock),
        .rst_ni (Reset),
        .push_i (push),
        .pop_i  (pop),
        .data_i (pc_q),
        .top_o  (st_top),
        .full_o (st_full),
        .empty_o(st_empty)
    );

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wdata     = '0;
        taken     = 1'b0;
        target    = IADDR_WIDTH'(dst);
        push      = 1'b0;
        pop       = 1'b0;
        set_err   = 1'b0;
        pix_we_d  = 1'b0;
        illegal_d = 1'b0;
        if (state_q == ST_RUN) begin
            case (op_e'(op))
                OP_NOP:  ;
                OP_STO:  begin wr_en = 1'b1; wdata = imm; end
                OP_ADD:  begin wr_en = 1'b1; wdata = rs1 + rs0; end
                OP_SUB:  begin wr_en = 1'b1; wdata = rs1 - rs0; end
                OP_INC:  begin wr_en = 1'b1; wdata = rs1 + DATA_WIDTH'(1); end
                OP_AND:  begin wr_en = 1'b1; wdata = rs1 & rs0; end
                OP_OR:   begin wr_en = 1'b1; wdata = rs1 | rs0; end
                OP_BGE:  taken = (rs1 >= rs0);
                OP_BLE:  taken = (rs1 <= rs0);
                OP_BEQ:  taken = (rs1 == rs0);
                OP_JMP:  taken = 1'b1;
                OP_CALL: begin
                    if (!st_full) begin
                        push  = 1'b1;
                        taken = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!st_empty) begin
                        pop    = 1'b1;
                        taken  = 1'b1;
                        target = st_top;
                    end else begin
                        set_err = 1'b1;
                    end
                end
                OP_VGA:  pix_we_d = 1'b1;
                OP_HALT: state_d = ST_HALT;
                default: illegal_d = 1'b1;
            endcase
        end
        fetch_addr = !Reset ? '0 : (taken ? target : pc_q);
    end

    // IR and pc only advance while the next state is RUN, so HALT freezes fetch on its own edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_RUN;
            pc_q      <= '0;
            ir_q      <= INSTR_NOP;
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
            pix_we_q  <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            pix_col_q <= '0;
        end else begin
            state_q   <= state_d;
            if (state_d == ST_RUN) begin
                ir_q <= bus.iRomData;
                pc_q <= fetch_addr + IADDR_WIDTH'(1);
            end
            err_q     <= err_q | set_err;
            illegal_q <= illegal_d;
            pix_we_q  <= pix_we_d;
            if (pix_we_d) begin
                pix_x_q   <= rs1[7:0];
                pix_y_q   <= rs0[7:0];
                pix_col_q <= dst[PIXEL_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && wr_en) begin
            rf_q[dst[REG_ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    assign bus.oRomAddr  = fetch_addr;
    assign bus.oPixWe    = pix_we_q;
    assign bus.oPixX     = pix_x_q;
    assign bus.oPixY     = pix_y_q;
    assign bus.oPixColor = pix_col_q;
    assign bus.oHalted   = (state_q == ST_HALT);
    assign bus.oStackErr = err_q;
    assign bus.oIllegal  = illegal_q;
endmodule

// File: tb/tb_mini_alu_core.sv
// Scoreboard bench for mini_alu_core: a directed ROM program with per-cycle
// expectations and an in-order pixel-write queue.
module tb_mini_alu_core;
    import mini_alu_pkg::*;

    localparam int unsigned IW = 16;
    localparam int unsigned PW = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    mini_alu_core_if #(.IADDR_WIDTH(IW), .PIXEL_WIDTH(PW)) bus ();

    mini_alu_core #(
        .DATA_WIDTH    (16),
        .IADDR_WIDTH   (IW),
        .REG_ADDR_WIDTH(3),
        .STACK_DEPTH   (2),
        .PIXEL_WIDTH   (PW)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    logic [27:0] rom [256];
    assign bus.iRomData = rom[bus.oRomAddr[7:0]];

    typedef enum int {F_ADDR, F_HALT, F_ERR, F_ILL, F_WE} fld_e;
    typedef struct {
        int          k;
        fld_e        f;
        int unsigned v;
    } exp_t;
    typedef struct {
        logic [7:0]    x;
        logic [7:0]    y;
        logic [PW-1:0] c;
    } pix_t;

    exp_t exp_q[$];
    pix_t pix_q[$];
    int   checks = 0;
    int   errors = 0;
    int   kcnt   = 0;

    task automatic expect_at(input int k, input fld_e f, input int unsigned v);
        exp_t e;
        e.k = k;
        e.f = f;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_pix(input logic [7:0] x, input logic [7:0] y, input logic [PW-1:0] c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        pix_q.push_back(p);
    endtask

    function automatic string fname(input fld_e f);
        case (f)
            F_ADDR:  return "oRomAddr";
            F_HALT:  return "oHalted";
            F_ERR:   return "oStackErr";
            F_ILL:   return "oIllegal";
            default: return "oPixWe";
        endcase
    endfunction

    function automatic int unsigned actual(input fld_e f);
        case (f)
            F_ADDR:  return int'(bus.oRomAddr);
            F_HALT:  return int'(bus.oHalted);
            F_ERR:   return int'(bus.oStackErr);
            F_ILL:   return int'(bus.oIllegal);
            default: return int'(bus.oPixWe);
        endcase
    endfunction

    // Monitor: negedge number kcnt matches the cycle index used by expect_at.
    always @(negedge Clock) begin
        int          idx;
        int unsigned act;
        pix_t        p;
        kcnt = kcnt + 1;
        idx  = 0;
        while (idx < exp_q.size()) begin
            if (exp_q[idx].k == kcnt) begin
                act    = actual(exp_q[idx].f);
                checks = checks + 1;
                if (act != exp_q[idx].v) begin
                    errors = errors + 1;
                    $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                             fname(exp_q[idx].f), kcnt, act, exp_q[idx].v);
                end
                exp_q.delete(idx);
            end else begin
                idx = idx + 1;
            end
        end
        if (bus.oPixWe === 1'b1) begin
            checks = checks + 1;
            if (pix_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL pixel cycle %0d: got unexpected write x=0x%0h y=0x%0h c=%0d, expected none",
                         kcnt, bus.oPixX, bus.oPixY, bus.oPixColor);
            end else begin
                p = pix_q.pop_front();
                if (bus.oPixX !== p.x || bus.oPixY !== p.y || bus.oPixColor !== p.c) begin
                    errors = errors + 1;
                    $display("FAIL pixel cycle %0d: got x=0x%0h y=0x%0h c=%0d, expected x=0x%0h y=0x%0h c=%0d",
                             kcnt, bus.oPixX, bus.oPixY, bus.oPixColor, p.x, p.y, p.c);
                end
            end
        end
    end

    // Fetch address seen at cycles 4..37 as the program walks ALU, branch, call and halt code.
    int unsigned seq [34] = '{
        'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09,
        'h0C, 'h0D, 'h0E, 'h20, 'h21, 'h22, 'h10, 'h30, 'h40, 'h31, 'h11,
        'h50, 'h58, 'h60, 'h61, 'h59, 'h51, 'h5C, 'h5D,
        'h80, 'h81, 'h82, 'h83, 'h84, 'h85
    };

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = INSTR_NOP;
        rom['h00] = mk_instr(OP_STO,  8'd1, 8'h00, 8'h05);
        rom['h01] = mk_instr(OP_STO,  8'd2, 8'h00, 8'h07);
        rom['h02] = mk_instr(OP_SUB,  8'd3, 8'd1,  8'd2);
        rom['h03] = mk_instr(OP_ADD,  8'd4, 8'd2,  8'd1);
        rom['h04] = mk_instr(OP_AND,  8'd5, 8'd1,  8'd2);
        rom['h05] = mk_instr(OP_OR,   8'd6, 8'd1,  8'd2);
        rom['h06] = mk_instr(OP_VGA,  8'd1, 8'd4,  8'd5);
        rom['h07] = mk_instr(OP_VGA,  8'd2, 8'd6,  8'd3);
        rom['h08] = mk_instr(OP_STO,  8'd7, 8'hFF, 8'hFE);
        rom['h09] = mk_instr(OP_BEQ,  8'h0C, 8'd3, 8'd7);
        rom['h0A] = mk_instr(OP_HALT, 8'h00, 8'h00, 8'h00);
        rom['h0B] = mk_instr(OP_HALT, 8'h00, 8'h00, 8'h00);
        rom['h0C] = mk_instr(OP_STO,  8'd1, 8'h00, 8'h03);
        rom['h0D] = mk_instr(OP_STO,  8'd2, 8'h00, 8'h03);
        rom['h0E] = mk_instr(OP_BEQ,  8'h20, 8'd1, 8'd2);
        rom['h20] = mk_instr(OP_STO,  8'd2, 8'h00, 8'h04);
        rom['h21] = mk_instr(OP_BEQ,  8'h70, 8'd1, 8'd2);
        rom['h22] = mk_instr(OP_JMP,  8'h10, 8'h00, 8'h00);
        rom['h10] = mk_instr(OP_CALL, 8'h30, 8'h00, 8'h00);
        rom['h30] = mk_instr(OP_CALL, 8'h40, 8'h00, 8'h00);
        rom['h40] = mk_instr(OP_RET,  8'h00, 8'h00, 8'h00);
        rom['h31] = mk_instr(OP_RET,  8'h00, 8'h00, 8'h00);
        rom['h11] = mk_instr(OP_JMP,  8'h50, 8'h00, 8'h00);
        rom['h50] = mk_instr(OP_CALL, 8'h58, 8'h00, 8'h00);
        rom['h51] = mk_instr(OP_JMP,  8'h5C, 8'h00, 8'h00);
        rom['h58] = mk_instr(OP_CALL, 8'h60, 8'h00, 8'h00);
        rom['h59] = mk_instr(OP_RET,  8'h00, 8'h00, 8'h00);
        rom['h60] = mk_instr(OP_CALL, 8'h70, 8'h00, 8'h00);
        rom['h61] = mk_instr(OP_RET,  8'h00, 8'h00, 8'h00);
        rom['h5C] = mk_instr(OP_RET,  8'h00, 8'h00, 8'h00);
        rom['h5D] = mk_instr(OP_JMP,  8'h80, 8'h00, 8'h00);
        rom['h70] = mk_instr(OP_HALT, 8'h00, 8'h00, 8'h00);
        rom['h80] = mk_instr(OP_STO,  8'd1, 8'h00, 8'h12);
        rom['h81] = mk_instr(OP_STO,  8'd2, 8'h00, 8'h34);
        rom['h82] = mk_instr(OP_VGA,  8'd5, 8'd1,  8'd2);
        rom['h83] = 28'hF000000;
        rom['h84] = mk_instr(OP_HALT, 8'h00, 8'h00, 8'h00);

        expect_at(1, F_ADDR, 0);
        expect_at(1, F_HALT, 0);
        expect_at(1, F_ERR,  0);
        expect_at(1, F_ILL,  0);
        expect_at(1, F_WE,   0);
        expect_at(2, F_ADDR, 0);
        expect_at(3, F_ADDR, 0);
        for (int i = 0; i < 34; i++) expect_at(4 + i, F_ADDR, seq[i]);
        expect_at(4,  F_HALT, 0);
        expect_at(11, F_WE,   1);
        expect_at(12, F_WE,   1);
        expect_at(13, F_WE,   0);
        expect_at(24, F_ERR,  0);
        expect_at(27, F_ERR,  0);
        expect_at(28, F_ERR,  1);
        expect_at(32, F_ERR,  1);
        expect_at(36, F_WE,   1);
        expect_at(36, F_ILL,  0);
        expect_at(37, F_ILL,  1);
        expect_at(37, F_WE,   0);
        expect_at(37, F_HALT, 0);
        expect_at(38, F_ILL,  0);
        for (int k = 38; k <= 47; k++) begin
            expect_at(k, F_ADDR, 'h85);
            expect_at(k, F_HALT, 1);
        end
        expect_at(48, F_ADDR, 0);
        expect_at(48, F_HALT, 1);
        expect_at(48, F_ERR,  1);
        expect_at(49, F_ADDR, 0);
        expect_at(49, F_HALT, 0);
        expect_at(49, F_ERR,  0);
        expect_at(49, F_WE,   0);
        expect_at(49, F_ILL,  0);
        expect_at(50, F_ADDR, 0);

        expect_pix(8'h0C, 8'h05, 3'd1);
        expect_pix(8'h07, 8'hFE, 3'd2);
        expect_pix(8'h12, 8'h34, 3'd5);

        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        repeat (45) @(posedge Clock);
        #1 Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL leftover_expect: got %0d unchecked entries, expected 0", exp_q.size());
        end
        checks = checks + 1;
        if (pix_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL leftover_pixel: got %0d missing pixel writes, expected 0", pix_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
